// File: rtl/reg_file_sb_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_sb_pkg
//   Shared constants and types for the integer register file. Decode and
//   hazard units use the same definitions.
//
//   XLEN       default data width
//   NREGS      default number of architectural registers
//   REG_AW     register address width for the default configuration
//   reg_addr_t register address type for the default configuration
//   MAX_REGS   upper bound on NREGS for any configuration
//   reg_mask() bit r set when register r exists and may be written/tracked
// -----------------------------------------------------------------------------
package reg_file_sb_pkg;

    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int REG_AW   = $clog2(NREGS);
    localparam int MAX_REGS = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;

    // One bit per address. Clear for the hard-wired zero register and for
    // addresses beyond the implemented register count. Reads of a clear
    // address return zero; writes and issues to it are dropped.
    function automatic logic [MAX_REGS-1:0] reg_mask(input int nregs, input bit zero_reg);
        logic [MAX_REGS-1:0] m;
        m = '0;
        for (int r = 0; r < MAX_REGS; r++) begin
            m[r] = (r < nregs) && !(zero_reg && (r == 0));
        end
        return m;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// -----------------------------------------------------------------------------
// reg_file_sb_if
//   Bundle of register-file signals between the pipeline and reg_file_sb.
//
//   i_rd_addr  NRD*AW    read addresses, port k at [k*AW +: AW]
//   o_rd_data  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
//   o_rd_busy  NRD       port k register has an outstanding write
//   i_wr_en    1         writeback strobe
//   i_wr_addr  AW        writeback destination
//   i_wr_data  XLEN      writeback data
//   i_iss_en   1         instruction issued with a destination
//   i_iss_addr AW        destination being marked pending
//   i_flush    1         drop all pending marks
//   o_pend_cnt AW+1      number of pending registers
//
//   master: pipeline side (drives i_*), slave: register file (drives o_*).
// -----------------------------------------------------------------------------
interface reg_file_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   i_rd_addr;
    logic [NRD*XLEN-1:0] o_rd_data;
    logic [NRD-1:0]      o_rd_busy;
    logic                i_wr_en;
    logic [AW-1:0]       i_wr_addr;
    logic [XLEN-1:0]     i_wr_data;
    logic                i_iss_en;
    logic [AW-1:0]       i_iss_addr;
    logic                i_flush;
    logic [AW:0]         o_pend_cnt;

    modport master (
        output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
               i_iss_en, i_iss_addr, i_flush,
        input  o_rd_data, o_rd_busy, o_pend_cnt
    );

    modport slave (
        input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
               i_iss_en, i_iss_addr, i_flush,
        output o_rd_data, o_rd_busy, o_pend_cnt
    );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_file_sb_scoreboard
//   Pending-write scoreboard: one bit per register, set on issue, cleared on
//   writeback or flush. Reports per-read-port busy flags and a registered
//   count of pending registers.
//
//   clk       in   1       clock, rising edge
//   rst_n     in   1       asynchronous reset, active low
//   rd_addr   in   NRD*AW  read addresses, port k at [k*AW +: AW]
//   wr_en     in   1       writeback strobe
//   wr_addr   in   AW      writeback destination
//   iss_en    in   1       issue strobe
//   iss_addr  in   AW      destination being marked pending
//   flush     in   1       clear every pending mark
//   rd_busy   out  NRD     port k register is pending and not being written
//   pend_cnt  out  AW+1    population count of the pending bits
// -----------------------------------------------------------------------------
module reg_file_sb_scoreboard #(
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    output logic [NRD-1:0]    rd_busy,
    output logic [AW:0]       pend_cnt
);
    import reg_file_sb_pkg::*;

    // Pending bits are kept for every encodable address so any address can
    // index them directly; bits outside TRACK are forced to zero.
    localparam int NPOW = 1 << AW;
    localparam int CW   = AW + 1;

    localparam logic [MAX_REGS-1:0] MASK_FULL = reg_mask(NREGS, ZERO_REG != 0);
    localparam logic [NPOW-1:0]     TRACK     = MASK_FULL[NPOW-1:0];

    logic [NPOW-1:0] pend_q;
    logic [NPOW-1:0] pend_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    // Next-state pending bits. Flush beats issue, issue beats writeback:
    // an issue and a writeback to the same register in one cycle means a new
    // producer has just claimed it, so it must stay pending.
    always_comb begin
        // NOTE: every variable gets a value before any branch so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        pend_d = pend_q;
        cnt_d  = '0;
        for (int r = 0; r < NPOW; r++) begin
            if (flush) begin
                pend_d[r] = 1'b0;
            end else if (iss_en && (iss_addr == AW'(r))) begin
                pend_d[r] = 1'b1;
            end else if (wr_en && (wr_addr == AW'(r))) begin
                pend_d[r] = 1'b0;
            end
        end
        pend_d = pend_d & TRACK;
        for (int r = 0; r < NPOW; r++) begin
            cnt_d = cnt_d + CW'(pend_d[r]);
        end
    end

    // The count is registered alongside the bits it summarises, so it always
    // equals the popcount of pend_q and can never exceed the tracked set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // A writeback landing this cycle hides the pending mark: the bypass
    // already supplies the value, so decode need not stall on it.
    for (genvar k = 0; k < NRD; k++) begin : g_busy
        logic [AW-1:0] a;
        assign a          = rd_addr[k*AW +: AW];
        assign rd_busy[k] = pend_q[a] & ~(wr_en && (wr_addr == a));
    end

    assign pend_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//   Parametrised integer register file with a pending-write scoreboard.
//   NRD combinational read ports with same-cycle writeback bypass, one
//   writeback port, one issue port that marks destinations pending.
//
//   Parameters
//     XLEN      data width
//     NREGS     architectural registers (2..32)
//     NRD       read ports (1..4)
//     ZERO_REG  1: register 0 reads zero, is never stored, never pending
//
//   Ports
//     clk    in  clock, rising edge
//     rst_n  in  asynchronous reset, active low
//     bus    slave side of reg_file_sb_if (read, writeback, issue, flush,
//            busy flags and pending count)
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int XLEN     = reg_file_sb_pkg::XLEN,
    parameter int NREGS    = reg_file_sb_pkg::NREGS,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);
    import reg_file_sb_pkg::*;

    localparam int AW   = $clog2(NREGS);
    localparam int NPOW = 1 << AW;

    // WMASK[a] is set only for addresses that hold real storage. Reads of
    // other addresses return zero and writes to them are dropped.
    localparam logic [MAX_REGS-1:0] MASK_FULL = reg_mask(NREGS, ZERO_REG != 0);
    localparam logic [NPOW-1:0]     WMASK     = MASK_FULL[NPOW-1:0];

    // The array spans every encodable address so read indexing never goes
    // out of bounds; entries outside WMASK are never written and stay zero.
    logic [XLEN-1:0] mem_q [NPOW];

    // NOTE: the register contents must read zero straight out of reset, so
    // this array is built from resettable flops rather than a RAM macro and
    // every entry is cleared in the reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NPOW; r++) begin
                mem_q[r] <= '0;
            end
        end else if (bus.i_wr_en && WMASK[bus.i_wr_addr]) begin
            mem_q[bus.i_wr_addr] <= bus.i_wr_data;
        end
    end

    // Per-port read mux: masked address first (zero register, out of range),
    // then bypass of the writeback landing this cycle, then stored value.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] rd;

        assign a = bus.i_rd_addr[k*AW +: AW];

        always_comb begin
            if (!WMASK[a]) begin
                rd = '0;
            end else if (bus.i_wr_en && (bus.i_wr_addr == a)) begin
                rd = bus.i_wr_data;
            end else begin
                rd = mem_q[a];
            end
        end

        assign bus.o_rd_data[k*XLEN +: XLEN] = rd;
    end

    reg_file_sb_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (bus.i_rd_addr),
        .wr_en    (bus.i_wr_en),
        .wr_addr  (bus.i_wr_addr),
        .iss_en   (bus.i_iss_en),
        .iss_addr (bus.i_iss_addr),
        .flush    (bus.i_flush),
        .rd_busy  (bus.o_rd_busy),
        .pend_cnt (bus.o_pend_cnt)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//   Directed bench for reg_file_sb. Three configurations share clk/rst_n:
//     u_dut32  XLEN=32 NREGS=32 NRD=2 ZERO_REG=1   (main behaviour)
//     u_dut16  XLEN=32 NREGS=16 NRD=3 ZERO_REG=0   (stored/pending x0, reset)
//     u_dut12  XLEN=32 NREGS=12 NRD=1 ZERO_REG=1   (addresses beyond NREGS)
//   Inputs change 1 ns after a rising edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

    logic clk;
    logic rst_n;

    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus32 ();
    reg_file_sb_if #(.XLEN(32), .NREGS(16), .NRD(3)) bus16 ();
    reg_file_sb_if #(.XLEN(32), .NREGS(12), .NRD(1)) bus12 ();

    reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32.slave)
    );

    reg_file_sb #(.XLEN(32), .NREGS(16), .NRD(3), .ZERO_REG(0)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16.slave)
    );

    reg_file_sb #(.XLEN(32), .NREGS(12), .NRD(1), .ZERO_REG(1)) u_dut12 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus12.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus32.i_wr_en = 1'b0; bus32.i_iss_en = 1'b0; bus32.i_flush = 1'b0;
        bus16.i_wr_en = 1'b0; bus16.i_iss_en = 1'b0; bus16.i_flush = 1'b0;
        bus12.i_wr_en = 1'b0; bus12.i_iss_en = 1'b0; bus12.i_flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        idle();
        bus32.i_rd_addr = '0; bus32.i_wr_addr = '0; bus32.i_wr_data = '0; bus32.i_iss_addr = '0;
        bus16.i_rd_addr = '0; bus16.i_wr_addr = '0; bus16.i_wr_data = '0; bus16.i_iss_addr = '0;
        bus12.i_rd_addr = '0; bus12.i_wr_addr = '0; bus12.i_wr_data = '0; bus12.i_iss_addr = '0;
        #2;
        for (int a = 0; a < 32; a++) begin
            bus32.i_rd_addr = {5'(a), 5'(a)};
            #1;
            check($sformatf("rst_data0_x%0d", a), bus32.o_rd_data[31:0],  64'h0);
            check($sformatf("rst_data1_x%0d", a), bus32.o_rd_data[63:32], 64'h0);
            check($sformatf("rst_busy_x%0d", a),  bus32.o_rd_busy,        64'h0);
        end
        check("rst_cnt32", bus32.o_pend_cnt, 64'h0);
        check("rst_cnt16", bus16.o_pend_cnt, 64'h0);
        check("rst_cnt12", bus12.o_pend_cnt, 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---------------- x0 write ignored ----------------
        bus32.i_wr_en = 1'b1; bus32.i_wr_addr = 5'd0; bus32.i_wr_data = 32'hFFFF_FFFF;
        bus32.i_rd_addr = {5'd0, 5'd0};
        #1;
        check("x0_bypass", bus32.o_rd_data[31:0], 64'h0);
        tick(); idle(); #1;
        check("x0_stored", bus32.o_rd_data[31:0], 64'h0);

        // ---------------- bypass then stored ----------------
        bus32.i_wr_en = 1'b1; bus32.i_wr_addr = 5'd5; bus32.i_wr_data = 32'hDEAD_BEEF;
        bus32.i_rd_addr = {5'd6, 5'd5};
        #1;
        check("x5_bypass",  bus32.o_rd_data[31:0],  64'hDEAD_BEEF);
        check("x6_unwritten", bus32.o_rd_data[63:32], 64'h0);
        tick(); idle(); #1;
        check("x5_stored",  bus32.o_rd_data[31:0],  64'hDEAD_BEEF);
        check("x5_busy",    bus32.o_rd_busy,        64'h0);

        // ---------------- issue then writeback ----------------
        bus32.i_iss_en = 1'b1; bus32.i_iss_addr = 5'd7;
        bus32.i_rd_addr = {5'd0, 5'd7};
        #1;
        check("x7_busy_before_edge", bus32.o_rd_busy[0], 64'h0);
        check("cnt_before_issue",    bus32.o_pend_cnt,   64'h0);
        tick(); idle(); #1;
        check("x7_busy_after_issue", bus32.o_rd_busy[0], 64'h1);
        check("cnt_after_issue",     bus32.o_pend_cnt,   64'h1);
        bus32.i_wr_en = 1'b1; bus32.i_wr_addr = 5'd7; bus32.i_wr_data = 32'h0000_1234;
        #1;
        check("x7_busy_wb_cycle", bus32.o_rd_busy[0],    64'h0);
        check("x7_data_wb_cycle", bus32.o_rd_data[31:0], 64'h1234);
        check("cnt_wb_cycle",     bus32.o_pend_cnt,      64'h1);
        tick(); idle(); #1;
        check("cnt_after_wb",     bus32.o_pend_cnt,      64'h0);
        check("x7_busy_after_wb", bus32.o_rd_busy[0],    64'h0);
        check("x7_data_after_wb", bus32.o_rd_data[31:0], 64'h1234);

        // ---------------- issue + writeback same register ----------------
        bus32.i_iss_en = 1'b1; bus32.i_iss_addr = 5'd3;
        bus32.i_wr_en  = 1'b1; bus32.i_wr_addr  = 5'd3; bus32.i_wr_data = 32'h55;
        bus32.i_rd_addr = {5'd3, 5'd0};
        tick(); idle(); #1;
        check("x3_busy_iss_wins", bus32.o_rd_busy[1],     64'h1);
        check("x3_data_written",  bus32.o_rd_data[63:32], 64'h55);
        check("cnt_iss_wins",     bus32.o_pend_cnt,       64'h1);

        // ---------------- fill scoreboard, then flush ----------------
        for (int r = 1; r < 32; r++) begin
            bus32.i_iss_en = 1'b1; bus32.i_iss_addr = 5'(r);
            tick();
        end
        idle();
        bus32.i_rd_addr = {5'd31, 5'd1};
        #1;
        check("cnt_full",   bus32.o_pend_cnt, 64'd31);
        check("busy_full",  bus32.o_rd_busy,  64'h3);
        bus32.i_iss_en = 1'b1; bus32.i_iss_addr = 5'd0;
        bus32.i_rd_addr = {5'd31, 5'd0};
        tick(); idle(); #1;
        check("cnt_x0_issue_ignored", bus32.o_pend_cnt,  64'd31);
        check("x0_never_busy",        bus32.o_rd_busy,   64'h2);
        bus32.i_flush  = 1'b1;
        bus32.i_iss_en = 1'b1; bus32.i_iss_addr = 5'd9;
        bus32.i_wr_en  = 1'b1; bus32.i_wr_addr  = 5'd10; bus32.i_wr_data = 32'hAB;
        bus32.i_rd_addr = {5'd10, 5'd9};
        tick(); idle(); #1;
        check("cnt_after_flush",     bus32.o_pend_cnt,       64'h0);
        check("busy_after_flush",    bus32.o_rd_busy,        64'h0);
        check("x10_written_in_flush", bus32.o_rd_data[63:32], 64'hAB);
        check("x9_unwritten",        bus32.o_rd_data[31:0],  64'h0);
        bus32.i_rd_addr = {5'd5, 5'd3};
        #1;
        check("x3_kept_after_flush", bus32.o_rd_data[31:0],  64'h55);
        check("x5_kept_after_flush", bus32.o_rd_data[63:32], 64'hDEAD_BEEF);

        // ---------------- NREGS=16, NRD=3, no zero register ----------------
        bus16.i_wr_en  = 1'b1; bus16.i_wr_addr  = 4'd0; bus16.i_wr_data = 32'hA5A5;
        bus16.i_iss_en = 1'b1; bus16.i_iss_addr = 4'd15;
        bus16.i_rd_addr = {4'd1, 4'd15, 4'd0};
        #1;
        check("r16_x0_bypass", bus16.o_rd_data[31:0], 64'hA5A5);
        check("r16_busy_pre",  bus16.o_rd_busy,       64'h0);
        tick(); idle(); #1;
        check("r16_x0_stored", bus16.o_rd_data[31:0], 64'hA5A5);
        check("r16_busy_x15",  bus16.o_rd_busy,       64'h2);
        check("r16_cnt_1",     bus16.o_pend_cnt,      64'h1);
        bus16.i_iss_en = 1'b1; bus16.i_iss_addr = 4'd0;
        bus16.i_wr_en  = 1'b1; bus16.i_wr_addr  = 4'd15; bus16.i_wr_data = 32'h77;
        #1;
        check("r16_x15_busy_wb",   bus16.o_rd_busy[1],     64'h0);
        check("r16_x15_bypass",    bus16.o_rd_data[63:32], 64'h77);
        tick(); idle(); #1;
        check("r16_busy_x0",       bus16.o_rd_busy,        64'h1);
        check("r16_cnt_x0",        bus16.o_pend_cnt,       64'h1);
        check("r16_x15_stored",    bus16.o_rd_data[63:32], 64'h77);
        check("r16_port2_x1",      bus16.o_rd_data[95:64], 64'h0);

        // ---------------- NREGS=12: addresses 12..15 do not exist ----------------
        bus12.i_wr_en  = 1'b1; bus12.i_wr_addr  = 4'd13; bus12.i_wr_data = 32'hFF;
        bus12.i_iss_en = 1'b1; bus12.i_iss_addr = 4'd13;
        bus12.i_rd_addr = 4'd13;
        #1;
        check("r12_oor_no_bypass", bus12.o_rd_data, 64'h0);
        tick(); idle(); #1;
        check("r12_oor_data", bus12.o_rd_data,  64'h0);
        check("r12_oor_busy", bus12.o_rd_busy,  64'h0);
        check("r12_oor_cnt",  bus12.o_pend_cnt, 64'h0);
        bus12.i_wr_en  = 1'b1; bus12.i_wr_addr  = 4'd11; bus12.i_wr_data = 32'h11;
        bus12.i_iss_en = 1'b1; bus12.i_iss_addr = 4'd11;
        bus12.i_rd_addr = 4'd11;
        tick(); idle(); #1;
        check("r12_x11_data", bus12.o_rd_data,  64'h11);
        check("r12_x11_busy", bus12.o_rd_busy,  64'h1);
        check("r12_x11_cnt",  bus12.o_pend_cnt, 64'h1);

        // ---------------- asynchronous reset mid-operation ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_r16_cnt",   bus16.o_pend_cnt,        64'h0);
        check("arst_r16_busy",  bus16.o_rd_busy,         64'h0);
        check("arst_r16_x0",    bus16.o_rd_data[31:0],   64'h0);
        check("arst_r16_x15",   bus16.o_rd_data[63:32],  64'h0);
        check("arst_r32_x3",    bus32.o_rd_data[31:0],   64'h0);
        check("arst_r12_cnt",   bus12.o_pend_cnt,        64'h0);
        check("arst_r12_x11",   bus12.o_rd_data,         64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus16.i_iss_en = 1'b1; bus16.i_iss_addr = 4'd2;
        bus16.i_rd_addr = {4'd2, 4'd15, 4'd0};
        tick(); idle(); #1;
        check("post_rst_busy", bus16.o_rd_busy,  64'h4);
        check("post_rst_cnt",  bus16.o_pend_cnt, 64'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
